// File: rtl/ula_arbiter.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module      : ula_arbiter
// Description : Round-robin arbiter/sequencer sharing one ALU between two
//               requesters; handles sum/sub/iterative mult with timeout.
// Revision    : 1.0 - initial release
// ============================================================================
module ula_arbiter #(
    parameter int WIDTH   = 27,
    parameter int TIMEOUT = 64
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             req0,
    input  logic             req1,
    input  logic [WIDTH-1:0] a0,
    input  logic [WIDTH-1:0] b0,
    input  logic [WIDTH-1:0] a1,
    input  logic [WIDTH-1:0] b1,
    input  logic [1:0]       cmd0,
    input  logic [1:0]       cmd1,
    output logic             ack0,
    output logic             ack1,
    output logic [WIDTH-1:0] result0,
    output logic [WIDTH-1:0] result1,
    output logic             carry0,
    output logic             carry1,
    output logic             err0,
    output logic             err1,
    output logic             alu_start,
    output logic [WIDTH-1:0] alu_a,
    output logic [WIDTH-1:0] alu_b,
    output logic [1:0]       alu_cmd,
    input  logic             alu_done,
    input  logic [WIDTH-1:0] alu_result,
    input  logic             alu_carry,
    output logic             busy
);

    localparam int            CW         = $clog2(TIMEOUT + 1);
    localparam logic [CW-1:0] c_tmo      = CW'(TIMEOUT);
    localparam logic [CW-1:0] c_one      = CW'(1);
    localparam logic [1:0]    c_cmd_mult = 2'b00;
    localparam logic [1:0]    c_cmd_sum  = 2'b01;
    localparam logic [1:0]    c_cmd_ill  = 2'b11;

    localparam logic [1:0]    c_st_idle  = 2'd0;
    localparam logic [1:0]    c_st_issue = 2'd1;
    localparam logic [1:0]    c_st_wait  = 2'd2;
    localparam logic [1:0]    c_st_resp  = 2'd3;

    logic [1:0]       r_state;
    logic             r_ptr;
    logic             r_owner;
    logic [WIDTH-1:0] r_a;
    logic [WIDTH-1:0] r_b;
    logic [1:0]       r_cmd;
    logic [CW-1:0]    r_cnt;
    logic             r_alu_start;
    logic             r_ack0, r_ack1;
    logic [WIDTH-1:0] r_result0, r_result1;
    logic             r_carry0, r_carry1;
    logic             r_err0, r_err1;

    logic             w_any;
    logic             w_grant1;
    logic [1:0]       w_cmd;
    logic             w_fin;
    logic             w_fin_owner;
    logic [WIDTH-1:0] w_res;
    logic             w_car;
    logic             w_err;

    assign w_any       = req0 | req1;
    assign w_grant1    = req1 & (~req0 | r_ptr);
    assign w_cmd       = w_grant1 ? cmd1 : cmd0;
    assign w_fin_owner = (r_state == c_st_idle) ? w_grant1 : r_owner;

    // Response generation: illegal command short-circuits from IDLE; the first
    // WAIT cycle's alu_done is stale from the previous operation.
    always_comb begin
        w_fin = 1'b0;
        w_res = '0;
        w_car = 1'b0;
        w_err = 1'b0;
        case (r_state)
            c_st_idle: begin
                if (w_any && (w_cmd == c_cmd_ill)) begin
                    w_fin = 1'b1;
                    w_err = 1'b1;
                end
            end
            c_st_wait: begin
                if (r_cmd != c_cmd_mult) begin
                    w_fin = 1'b1;
                    w_res = alu_result;
                    w_car = (r_cmd == c_cmd_sum) & alu_carry;
                end else if ((r_cnt != c_one) && alu_done) begin
                    w_fin = 1'b1;
                    w_res = alu_result;
                end else if (r_cnt == c_tmo) begin
                    w_fin = 1'b1;
                    w_err = 1'b1;
                end
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state     <= c_st_idle;
            r_ptr       <= 1'b0;
            r_owner     <= 1'b0;
            r_a         <= '0;
            r_b         <= '0;
            r_cmd       <= '0;
            r_cnt       <= '0;
            r_alu_start <= 1'b0;
            r_ack0      <= 1'b0;
            r_ack1      <= 1'b0;
            r_result0   <= '0;
            r_result1   <= '0;
            r_carry0    <= 1'b0;
            r_carry1    <= 1'b0;
            r_err0      <= 1'b0;
            r_err1      <= 1'b0;
        end else begin
            r_ack0      <= 1'b0;
            r_ack1      <= 1'b0;
            r_alu_start <= 1'b0;
            case (r_state)
                c_st_idle: begin
                    if (w_any) begin
                        r_owner <= w_grant1;
                        r_ptr   <= ~w_grant1;
                        r_a     <= w_grant1 ? a1 : a0;
                        r_b     <= w_grant1 ? b1 : b0;
                        r_cmd   <= w_cmd;
                        if (w_fin) begin
                            r_state <= c_st_resp;
                        end else begin
                            r_state     <= c_st_issue;
                            r_alu_start <= 1'b1;
                        end
                    end
                end
                c_st_issue: begin
                    r_state <= c_st_wait;
                    r_cnt   <= c_one;
                end
                c_st_wait: begin
                    if (w_fin) begin
                        r_state <= c_st_resp;
                    end else if (r_cnt != c_tmo) begin
                        r_cnt <= r_cnt + c_one;
                    end
                end
                default: begin
                    r_state <= c_st_idle;
                end
            endcase

            if (w_fin) begin
                if (w_fin_owner) begin
                    r_ack1    <= 1'b1;
                    r_result1 <= w_res;
                    r_carry1  <= w_car;
                    r_err1    <= w_err;
                end else begin
                    r_ack0    <= 1'b1;
                    r_result0 <= w_res;
                    r_carry0  <= w_car;
                    r_err0    <= w_err;
                end
            end
        end
    end

    assign ack0      = r_ack0;
    assign ack1      = r_ack1;
    assign result0   = r_result0;
    assign result1   = r_result1;
    assign carry0    = r_carry0;
    assign carry1    = r_carry1;
    assign err0      = r_err0;
    assign err1      = r_err1;
    assign alu_start = r_alu_start;
    assign alu_a     = r_a;
    assign alu_b     = r_b;
    assign alu_cmd   = r_cmd;
    assign busy      = (r_state != c_st_idle);

endmodule
`default_nettype wire
